// File: rtl/clas_arbiter_if.sv
// Request/response bundle between two requesters and clas_arbiter.
// CLAS_ARB_OVF_EN adds the per-port signed-overflow response flag.
interface clas_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sel, req1_sel;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_result, rsp1_result;
  logic        rsp0_cout, rsp1_cout;
`ifdef CLAS_ARB_OVF_EN
  logic        rsp0_ovf, rsp1_ovf;
`endif

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_sel, req1_sel, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_cout, rsp1_cout
`ifdef CLAS_ARB_OVF_EN
    , input rsp0_ovf, rsp1_ovf
`endif
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_sel, req1_sel, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_result, rsp1_result, rsp0_cout, rsp1_cout
`ifdef CLAS_ARB_OVF_EN
    , output rsp0_ovf, rsp1_ovf
`endif
  );
endinterface

// File: rtl/clas_arbiter.sv
// Two-port round-robin arbiter sharing one 16-bit add/sub unit (clas_16bit).
// Define CLAS_ARB_OVF_EN to add the registered signed-overflow response flags.
module clas_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] result,
  output logic        c_out
);
  logic [15:0] w_bx, w_g, w_p;
  logic [16:0] w_c;

  // Subtract as a + ~b + 1; the final carry is then the no-borrow flag.
  always_comb begin
    w_bx   = b ^ {16{sel}};
    w_g    = a & w_bx;
    w_p    = a ^ w_bx;
    w_c    = '0;
    w_c[0] = sel;
    for (int unsigned i = 0; i < 16; i++)
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    result = w_p ^ w_c[15:0];
    c_out  = w_c[16];
  end
endmodule

module clas_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  output logic           busy,
  clas_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_ptr, r_gnt;
  logic [15:0] r_a, r_b, r_result;
  logic        r_sel, r_cout;
  logic        w_gnt_id, w_accept, w_rsp_hs;
  logic [15:0] w_sum;
  logic        w_cout;
`ifdef CLAS_ARB_OVF_EN
  logic        r_ovf, w_ovf;
`endif

  // Gating with rst_n keeps ready low while reset is held, even with valid high.
  always_comb begin
    w_gnt_id = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
    w_accept = rst_n & (r_state == IDLE) & (bus.req0_valid | bus.req1_valid);
    w_rsp_hs = (r_state == RESP) & (r_gnt ? bus.rsp1_ready : bus.rsp0_ready);
  end

  assign bus.req0_ready  = w_accept & ~w_gnt_id;
  assign bus.req1_ready  = w_accept &  w_gnt_id;
  assign bus.rsp0_valid  = (r_state == RESP) & ~r_gnt;
  assign bus.rsp1_valid  = (r_state == RESP) &  r_gnt;
  assign bus.rsp0_result = bus.rsp0_valid ? r_result : '0;
  assign bus.rsp1_result = bus.rsp1_valid ? r_result : '0;
  assign bus.rsp0_cout   = bus.rsp0_valid & r_cout;
  assign bus.rsp1_cout   = bus.rsp1_valid & r_cout;
  assign busy            = (r_state != IDLE);

  clas_16bit u_clas (
    .a      (r_a),
    .b      (r_b),
    .sel    (r_sel),
    .result (w_sum),
    .c_out  (w_cout)
  );

`ifdef CLAS_ARB_OVF_EN
  // Overflow when both effective operands share a sign the result does not.
  assign w_ovf        = (r_a[15] == (r_b[15] ^ r_sel)) & (w_sum[15] != r_a[15]);
  assign bus.rsp0_ovf = bus.rsp0_valid & r_ovf;
  assign bus.rsp1_ovf = bus.rsp1_valid & r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_gnt    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef CLAS_ARB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_gnt   <= w_gnt_id;
          r_a     <= w_gnt_id ? bus.req1_a   : bus.req0_a;
          r_b     <= w_gnt_id ? bus.req1_b   : bus.req0_b;
          r_sel   <= w_gnt_id ? bus.req1_sel : bus.req0_sel;
          r_state <= EXEC;
        end
        EXEC: begin
          r_result <= w_sum;
          r_cout   <= w_cout;
`ifdef CLAS_ARB_OVF_EN
          r_ovf    <= w_ovf;
`endif
          r_state  <= RESP;
        end
        RESP: if (w_rsp_hs) begin
          r_ptr   <= ~r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clas_arbiter.sv
// Directed bench for clas_arbiter: grant order, latency, stalls, reset abort.
// Overflow checks are compiled in when CLAS_ARB_OVF_EN is defined.
module tb_clas_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  clas_arbiter_if bus ();

  clas_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef CLAS_ARB_OVF_EN
  // Single req0 transaction starting in IDLE at a negedge; ends at the next IDLE negedge.
  task automatic run0(input logic [15:0] a, input logic [15:0] b, input logic sel,
                      input logic [15:0] er, input logic ec, input logic eo);
    bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel;
    bus.rsp0_ready = 1'b1;
    #1 chk("ovf_ready0", bus.req0_ready, 1'b1);
    @(negedge clk); bus.req0_valid = 1'b0;
    #1 chk("ovf_low_exec", bus.rsp0_ovf, 1'b0);
    @(negedge clk);
    #1 chk("ovf_result", bus.rsp0_result, er);
    chk("ovf_cout", bus.rsp0_cout, ec);
    chk("ovf_flag", bus.rsp0_ovf, eo);
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    // Reset state, with a request pending that must not be acknowledged
    #1 chk("rst_ready0", bus.req0_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    chk("rst_rsp0_result", bus.rsp0_result, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; bus.req0_valid = 1'b0;
    @(negedge clk);
    #1 chk("idle_busy", busy, 1'b0);

    // Single req0 add: ready now, response two cycles later
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h0F0F; bus.req0_sel = 1'b0;
    #1 chk("t1_ready0", bus.req0_ready, 1'b1);
    chk("t1_ready1", bus.req1_ready, 1'b0);
    @(negedge clk); bus.req0_valid = 1'b0;
    #1 chk("t1_ready0_exec", bus.req0_ready, 1'b0);
    chk("t1_valid_exec", bus.rsp0_valid, 1'b0);
    chk("t1_busy_exec", busy, 1'b1);
    chk("t1_result_gated", bus.rsp0_result, 16'h0000);
    @(negedge clk);
    #1 chk("t1_rsp_valid", bus.rsp0_valid, 1'b1);
    chk("t1_result", bus.rsp0_result, 16'h2143);
    chk("t1_cout", bus.rsp0_cout, 1'b0);
    chk("t1_rsp1_valid", bus.rsp1_valid, 1'b0);
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    #1 chk("t1_valid_after", bus.rsp0_valid, 1'b0);
    chk("t1_result_after", bus.rsp0_result, 16'h0000);
    chk("t1_busy_after", busy, 1'b0);

    // Reset pulse, then both valid: port 0 first, port 1 next
    rst_n = 1'b0; #1 rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h0001; bus.req0_sel = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0005; bus.req1_b = 16'h0007; bus.req1_sel = 1'b1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1 chk("t2_ready0", bus.req0_ready, 1'b1);
    chk("t2_ready1", bus.req1_ready, 1'b0);
    @(negedge clk); bus.req0_valid = 1'b0;
    #1 chk("t2_ready1_exec", bus.req1_ready, 1'b0);
    @(negedge clk);
    #1 chk("t2_rsp0_valid", bus.rsp0_valid, 1'b1);
    chk("t2_rsp0_result", bus.rsp0_result, 16'h0000);
    chk("t2_rsp0_cout", bus.rsp0_cout, 1'b1);
    chk("t2_rsp1_idle", bus.rsp1_valid, 1'b0);
    @(negedge clk);
    #1 chk("t2_ready1", bus.req1_ready, 1'b1);
    @(negedge clk); bus.req1_valid = 1'b0;
    @(negedge clk);
    #1 chk("t2_rsp1_valid", bus.rsp1_valid, 1'b1);
    chk("t2_rsp1_result", bus.rsp1_result, 16'hFFFE);
    chk("t2_rsp1_cout", bus.rsp1_cout, 1'b0);
    @(negedge clk);

    // Continuous contention: six grants alternating 0,1,... spaced 3 cycles
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0002; bus.req0_sel = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0009; bus.req1_b = 16'h0003; bus.req1_sel = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #1 chk($sformatf("rr_ready0_k%0d", k), bus.req0_ready, (k % 3 == 0) && ((k / 3) % 2 == 0));
      chk($sformatf("rr_ready1_k%0d", k), bus.req1_ready, (k % 3 == 0) && ((k / 3) % 2 == 1));
      @(negedge clk);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // rsp1 stalled five cycles while req0 waits
    bus.req1_valid = 1'b1; bus.req1_a = 16'h00FF; bus.req1_b = 16'h0001; bus.req1_sel = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1 chk("t4_ready1", bus.req1_ready, 1'b1);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1000; bus.req0_b = 16'h0001; bus.req0_sel = 1'b1;
    #1 chk("t4_ready0_exec", bus.req0_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk($sformatf("t4_stall_valid%0d", i), bus.rsp1_valid, 1'b1);
      chk($sformatf("t4_stall_result%0d", i), bus.rsp1_result, 16'h0100);
      chk($sformatf("t4_stall_ready0_%0d", i), bus.req0_ready, 1'b0);
    end
    bus.rsp1_ready = 1'b1;
    #1 chk("t4_ready0_hs", bus.req0_ready, 1'b0);
    @(negedge clk);
    #1 chk("t4_rsp1_done", bus.rsp1_valid, 1'b0);
    chk("t4_rsp1_res0", bus.rsp1_result, 16'h0000);
    chk("t4_ready0", bus.req0_ready, 1'b1);
    @(negedge clk); bus.req0_valid = 1'b0;
    @(negedge clk);
    #1 chk("t4_rsp0_result", bus.rsp0_result, 16'h0FFF);
    chk("t4_rsp0_cout", bus.rsp0_cout, 1'b1);
    @(negedge clk);

    // Reset during EXEC aborts the operation and clears the pointer
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0001; bus.req0_sel = 1'b1;
    bus.req1_valid = 1'b1;
    #1 chk("t5_ready1", bus.req1_ready, 1'b1);
    @(negedge clk); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1 chk("t5_busy_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk("t5_busy_rst", busy, 1'b0);
    chk("t5_rsp0_rst", bus.rsp0_valid, 1'b0);
    chk("t5_rsp1_rst", bus.rsp1_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("t5_no_rsp1", bus.rsp1_valid, 1'b0);
    chk("t5_busy_after", busy, 1'b0);
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1 chk("t5_regrant0", bus.req0_ready, 1'b1);
    chk("t5_regrant1", bus.req1_ready, 1'b0);
    @(negedge clk); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(negedge clk);
    #1 chk("t5_rsp0_result", bus.rsp0_result, 16'h0002);
    chk("t5_rsp0_cout", bus.rsp0_cout, 1'b1);
    @(negedge clk);

`ifdef CLAS_ARB_OVF_EN
    run0(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run0(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run0(16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clas_arbiter.md
CLAS_ARBITER -- requirements
Module: clas_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-004 reqN_ready  output  1  (N=0,1) operation of requester N accepted this cycle.
REQ-005 reqN_a, reqN_b  input  16 each  (N=0,1) operands, unsigned.
REQ-006 reqN_sel  input  1  (N=0,1) 0 = a+b, 1 = a-b.
REQ-007 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-008 rspN_ready  input  1  (N=0,1) requester N consumes the result.
REQ-009 rspN_result  output  16  (N=0,1) result, modulo 2^16.
REQ-010 rspN_cout  output  1  (N=0,1) carry out (add); no-borrow flag, 1 when a>=b (sub).
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block shall share exactly one clas_16bit instance (a, b, sel -> result, c_out) between the two requesters.
REQ-013 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-014 IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready combinationally that cycle, latch a/b/sel and the grant id, and go to EXEC; otherwise stay in IDLE.
REQ-015 reqN_ready shall be high only in IDLE, only for the granted N, and never for both N in the same cycle.
REQ-016 Arbitration: round-robin with a 1-bit priority pointer; with both valid, the pointer's port wins; with one valid, that port wins regardless of the pointer.
REQ-017 Pointer update: on response handshake, set to the port not just served.
REQ-018 EXEC: drive the latched operands into clas_16bit, register result and c_out, and go to RESP; EXEC lasts exactly one cycle.
REQ-019 RESP: assert rspN_valid for the granted N only; hold result/cout stable until rspN_ready; on the valid&ready cycle, go to IDLE.
REQ-020 Latency: accept in cycle T, rspN_valid first high in cycle T+2; back-to-back throughput is 1 operation per 3 cycles when rspN_ready is held high.
REQ-021 rspN_result and rspN_cout shall be 0 when rspN_valid is low.
REQ-022 Requests and operand changes while not in IDLE shall be ignored; a requester keeps valid high until it sees ready.
REQ-023 Wrap-around: 0xFFFF+0x0001 -> result 0x0000, cout 1; 0x0000-0x0001 -> result 0xFFFF, cout 0.

Reset
REQ-024 Asserting rst_n low shall immediately force: state IDLE, pointer 0, all ready/valid/busy 0, all results/couts 0.
REQ-025 Reset during EXEC or RESP shall discard the in-flight operation with no response issued.
REQ-026 The first grant after reset with both requesters valid shall go to requester 0.

Configuration
REQ-027 Macro CLAS_ARB_OVF_EN, when defined, shall add output rspN_ovf (1 bit, N=0,1): signed two's-complement overflow of the served operation, registered with result and 0 when rspN_valid is low.
REQ-028 Without CLAS_ARB_OVF_EN, the rspN_ovf ports and their logic shall not exist; all other behaviour shall be identical.

Verification
REQ-029 Reset, then req0 only: a=0x1234, b=0x0F0F, sel=0 -> req0_ready high 1 cycle; rsp0_valid 2 cycles later; result 0x2143, cout 0.
REQ-030 Both valid at the same time after reset: req0 (0xFFFF+0x0001) and req1 (0x0005-0x0007), rspN_ready held high -> req0 served first (result 0x0000, cout 1), then req1 (result 0xFFFE, cout 0).
REQ-031 Both valid continuously for 6 operations, rspN_ready high -> grants alternate 0,1,0,1,0,1; ready spacing 3 cycles.
REQ-032 rsp1_ready held low 5 cycles in RESP with req0 valid -> rsp1 result stable, req0_ready stays low until the cycle after rsp1 handshake.
REQ-033 rst_n pulsed low during EXEC -> no rspN_valid, busy 0 immediately, next both-valid grant goes to 0.
REQ-034 With CLAS_ARB_OVF_EN: 0x7FFF+0x0001 -> ovf 1; 0x8000-0x0001 -> ovf 1; 0x0003-0x0001 -> ovf 0.
